// File: rtl/collatz_result_display_pkg.sv
// Shared constants for the collatz result display: blanking values, active-low hex
// segment patterns, conversion FSM encoding and the double-dabble nibble adjust.
package collatz_result_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment
  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift
  function automatic logic [15:0] bcd_add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/collatz_result_display_seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module collatz_result_display_seg7_decode
  import collatz_result_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/collatz_result_display.sv
// Holds each accepted collatz result and scans it onto a 4-digit common-anode display.
// DISPLAY_BCD_EN selects decimal display via a double-dabble FSM; undefined gives hex.
//
// state | meaning
// IDLE  | ready for a result, digits show the last committed value
// CONV  | double-dabble running, one shift per cycle, input not accepted
module collatz_result_display
  import collatz_result_display_pkg::*;
#(
  parameter int SCAN_BITS = 16,
  parameter int VAL_W     = 15
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in0,
  output logic [VAL_W-1:0] held,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);

  logic                 transfer;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           idx;
  logic [15:0]          dig_q;
  logic [3:0]           digit;
  logic [6:0]           seg_d;
  logic                 dp_d;

  assign transfer = in_valid && in_ready;
  assign idx      = scan_cnt[SCAN_BITS-1 -: 2];
  assign digit    = dig_q[4*idx +: 4];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) held <= '0;
    else if (transfer) held <= in0;
  end

  collatz_result_display_seg7_decode u_decode (
    .nibble (digit),
    .seg    (seg_d)
  );

  // Enable, segments and dp all come from the same idx so they switch together
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scan_cnt <= '0;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      an       <= ~(4'b0001 << idx);
      seg      <= seg_d;
      dp       <= dp_d;
    end
  end

`ifdef DISPLAY_BCD_EN

  localparam int CW = $clog2(VAL_W + 1);

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] sh_q;
  logic [15:0]      bcd_q;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_shift;
  logic [CW-1:0]    bit_q;
  logic             ovf_acc_q;
  logic             ovf_q;
  logic             last_shift;

  assign in_ready  = (state_q == IDLE);
  assign bcd_adj   = bcd_add3(bcd_q);
  assign bcd_shift = {bcd_adj[14:0], sh_q[VAL_W-1]};
  assign dp_d      = !(ovf_q && (idx == 2'd3));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    last_shift = 1'b0;
    case (state_q)
      IDLE: if (in_valid) state_d = CONV;
      CONV: begin
        if (bit_q == CW'(VAL_W - 1)) begin
          last_shift = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A carry out of the thousands nibble means the value exceeds 9999
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh_q      <= '0;
      bcd_q     <= '0;
      bit_q     <= '0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
      dig_q     <= '0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        sh_q      <= in0;
        bcd_q     <= '0;
        bit_q     <= '0;
        ovf_acc_q <= 1'b0;
      end
    end else begin
      sh_q      <= sh_q << 1;
      bcd_q     <= bcd_shift;
      bit_q     <= bit_q + 1'b1;
      ovf_acc_q <= ovf_acc_q | bcd_adj[15];
      if (last_shift) begin
        dig_q <= bcd_shift;
        ovf_q <= ovf_acc_q | bcd_adj[15];
      end
    end
  end

`else

  assign in_ready = 1'b1;
  assign dp_d     = 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) dig_q <= '0;
    else if (transfer) dig_q <= 16'(in0);
  end

`endif

endmodule

// File: tb/tb_collatz_result_display.sv
// Directed bench for collatz_result_display with SCAN_BITS=4; follows DISPLAY_BCD_EN.
module tb_collatz_result_display;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in0 = '0;
  logic [14:0] held;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  collatz_result_display #(.SCAN_BITS(4), .VAL_W(15)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in0      (in0),
    .held     (held),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one full scan period, keeping the last segments/dp seen per digit
  task automatic capture();
    logic [3:0] pat;
    for (int k = 0; k < 4; k++) begin
      cap_seg[k] = 'x;
      cap_dp[k]  = 'x;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        pat = ~(4'b0001 << k);
        if (an == pat) begin
          cap_seg[k] = seg;
          cap_dp[k]  = dp;
        end
      end
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dps);
    repeat (17) @(negedge clk);
    capture();
    check({tag, "_seg3"}, 32'(cap_seg[3]), 32'(s3));
    check({tag, "_seg2"}, 32'(cap_seg[2]), 32'(s2));
    check({tag, "_seg1"}, 32'(cap_seg[1]), 32'(s1));
    check({tag, "_seg0"}, 32'(cap_seg[0]), 32'(s0));
    check({tag, "_dp"}, 32'({cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0]}), 32'(dps));
  endtask

`ifdef DISPLAY_BCD_EN
  // Transfers one value and returns how many sampled cycles in_ready stayed low
  task automatic bcd_transfer(input logic [14:0] v, output int lo);
    @(negedge clk);
    in0 = v;
    in_valid = 1'b1;
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b0;
        check("bcd_held", 32'(held), 32'(v));
      end
      if (!in_ready) lo++;
      else break;
    end
  endtask
`endif

  initial begin
    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_held", 32'(held), 32'h0);
      check("rst_ready", 32'(in_ready), 32'h1);
    end
    nrst = 1'b1;
    @(negedge clk);
    check("first_an", 32'(an), 32'hE);
    check_digits("rst_digits", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);

`ifndef DISPLAY_BCD_EN
    // Single hex transfer
    @(negedge clk);
    in0 = 15'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("hex_held", 32'(held), 32'h1234);
    check("hex_ready", 32'(in_ready), 32'h1);
    check_digits("hex_1234", 7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
    check("hex_ready_after", 32'(in_ready), 32'h1);

    // Back-to-back transfers, last one wins
    in0 = 15'h0ABC;
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b_held0", 32'(held), 32'h0ABC);
    in0 = 15'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_held1", 32'(held), 32'h7FFF);
    check_digits("hex_7fff", 7'h78, 7'h0E, 7'h0E, 7'h0E, 4'hF);

    // Mixed digits
    in0 = 15'h5A0D;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mix_held", 32'(held), 32'h5A0D);
    check_digits("hex_5a0d", 7'h12, 7'h08, 7'h40, 7'h21, 4'hF);

    // Reset clears the hold and digits
    nrst = 1'b0;
    #1;
    check("hrst_held", 32'(held), 32'h0);
    check("hrst_an", 32'(an), 32'hF);
    @(negedge clk);
    nrst = 1'b1;
    check_digits("hrst_digits", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
`else
    begin
      int lo;
      bcd_transfer(15'd1234, lo);
      check("bcd_busy_1234", 32'(lo), 32'd15);
      check_digits("bcd_1234", 7'h79, 7'h24, 7'h30, 7'h19, 4'hF);

      bcd_transfer(15'd32767, lo);
      check("bcd_busy_32767", 32'(lo), 32'd15);
      check_digits("bcd_32767", 7'h24, 7'h78, 7'h02, 7'h78, 4'h7);

      bcd_transfer(15'd9999, lo);
      check("bcd_busy_9999", 32'(lo), 32'd15);
      check_digits("bcd_9999", 7'h10, 7'h10, 7'h10, 7'h10, 4'hF);

      // Reset in the middle of a conversion
      @(negedge clk);
      in0 = 15'd1234;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_busy", 32'(in_ready), 32'h0);
      repeat (5) @(negedge clk);
      nrst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(in_ready), 32'h1);
      check("mid_rst_an", 32'(an), 32'hF);
      check("mid_rst_held", 32'(held), 32'h0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("mid_ready_after", 32'(in_ready), 32'h1);
      check_digits("mid_digits", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
